// File: rtl/thread_sched_if.sv
// External loader/unloader state-write port for thread_sched.
// The loader holds ext_wr_req until it sees ext_wr_ack.
interface thread_sched_if #(
  parameter int W = 3
) ();
  logic         ext_wr_req;
  logic [W-1:0] ext_wr_num;
  logic [1:0]   ext_wr_state;
  logic         ext_wr_ack;

  modport master (
    output ext_wr_req, ext_wr_num, ext_wr_state,
    input  ext_wr_ack
  );

  modport slave (
    input  ext_wr_req, ext_wr_num, ext_wr_state,
    output ext_wr_ack
  );
endinterface

// File: rtl/thread_sched.sv
// Thread-state table and round-robin scheduler for the sha256crypt CPU.
// Define THREAD_SCHED_STATS_EN to add the idle_cnt output.
module thread_sched #(
  parameter int N_CORES       = 3,
  parameter int N_THREADS     = 2 * N_CORES,
  parameter int N_THREADS_MSB = $clog2(N_THREADS) - 1
) (
  input  logic                     CLK,
  input  logic                     RST,
  thread_sched_if.slave            ext,
  input  logic [N_THREADS-1:0]     core_done,
  input  logic                     NEXT_THREAD,
  input  logic [1:0]               cpu_new_state,
  input  logic [N_THREADS_MSB:0]   ts_rd_num,
  output logic [1:0]               ts_rd,
  output logic [N_THREADS_MSB:0]   thread_num,
  output logic                     thread_running,
  output logic                     RELOAD,
`ifdef THREAD_SCHED_STATS_EN
  output logic [31:0]              idle_cnt,
`endif
  output logic                     err
);

  localparam int W = N_THREADS_MSB + 1;
  localparam logic [W-1:0] LAST = W'(N_THREADS - 1);

  typedef enum logic [1:0] {
    TS_NONE = 2'b00,
    TS_RDY  = 2'b01,
    TS_RUN  = 2'b10,
    TS_WAIT = 2'b11
  } ts_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_RUN
  } st_e;

  ts_e            tbl [N_THREADS];
  st_e            st;
  logic [W-1:0]   ahead_num;
  logic           ahead_valid;
  logic [W-1:0]   srch_num;
  logic           srch_valid;
  logic [W:0]     sum;
  logic           cpu_we;
  logic           ld_we;
  logic           ext_ok;
  logic           ahead_ok;
  logic [N_THREADS-1:0] hit;
  logic           done_err;

  assign ts_rd = (ts_rd_num <= LAST) ? tbl[ts_rd_num] : TS_NONE;

  assign cpu_we = (st == S_RUN) && NEXT_THREAD;
  assign ld_we  = (st == S_LOAD);

  // The current thread is owned by the CPU/loader while in LOAD or RUN.
  assign ext_ok = !RST && ext.ext_wr_req &&
                  !((st != S_IDLE) && (ext.ext_wr_num == thread_num));
  assign ext.ext_wr_ack = ext_ok;

  assign ahead_ok = ahead_valid && (tbl[ahead_num] == TS_RDY);

  // Lowest offset wins; offset N_THREADS is thread_num itself, idle only.
  always_comb begin
    srch_valid = 1'b0;
    srch_num   = '0;
    sum        = '0;
    for (int k = N_THREADS; k >= 1; k--) begin
      sum = {1'b0, thread_num} + (W+1)'(k);
      if (sum >= (W+1)'(N_THREADS))
        sum = sum - (W+1)'(N_THREADS);
      if (tbl[sum[W-1:0]] == TS_RDY &&
          (k != N_THREADS || st == S_IDLE)) begin
        srch_valid = 1'b1;
        srch_num   = sum[W-1:0];
      end
    end
  end

  always_comb begin
    hit      = '0;
    done_err = 1'b0;
    for (int i = 0; i < N_THREADS; i++) begin
      hit[i] = ((cpu_we || ld_we) && thread_num == W'(i)) ||
               (ext_ok && ext.ext_wr_num == W'(i));
      if (core_done[i] && (hit[i] || tbl[i] != TS_WAIT))
        done_err = 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < N_THREADS; i++)
        tbl[i] <= TS_NONE;
    end else begin
      for (int i = 0; i < N_THREADS; i++) begin
        if (cpu_we && thread_num == W'(i))
          tbl[i] <= ts_e'(cpu_new_state);
        else if (ld_we && thread_num == W'(i))
          tbl[i] <= TS_RUN;
        else if (ext_ok && ext.ext_wr_num == W'(i))
          tbl[i] <= ts_e'(ext.ext_wr_state);
        else if (core_done[i] && tbl[i] == TS_WAIT)
          tbl[i] <= TS_RDY;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST)
      err <= 1'b0;
    else if (done_err || (NEXT_THREAD && st != S_RUN))
      err <= 1'b1;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      st             <= S_IDLE;
      thread_num     <= '0;
      thread_running <= 1'b0;
      RELOAD         <= 1'b0;
      ahead_valid    <= 1'b0;
      ahead_num      <= '0;
    end else begin
      ahead_valid <= srch_valid;
      ahead_num   <= srch_num;
      RELOAD      <= 1'b0;
      unique case (st)
        S_IDLE: begin
          if (ahead_ok) begin
            st         <= S_LOAD;
            thread_num <= ahead_num;
            RELOAD     <= 1'b1;
          end
        end
        S_LOAD: begin
          st             <= S_RUN;
          thread_running <= 1'b1;
        end
        S_RUN: begin
          if (NEXT_THREAD) begin
            thread_running <= 1'b0;
            if (ahead_ok && ahead_num != thread_num) begin
              st         <= S_LOAD;
              thread_num <= ahead_num;
              RELOAD     <= 1'b1;
            end else begin
              st <= S_IDLE;
            end
          end
        end
        default: st <= S_IDLE;
      endcase
    end
  end

`ifdef THREAD_SCHED_STATS_EN
  always_ff @(posedge CLK) begin
    if (RST)
      idle_cnt <= '0;
    else if (st == S_IDLE && idle_cnt != 32'hFFFF_FFFF)
      idle_cnt <= idle_cnt + 32'd1;
  end
`endif

endmodule

// File: tb/tb_thread_sched.sv
// Scoreboard bench for thread_sched: expected RELOAD threads are queued
// by the stimulus and checked by an independent monitor.
module tb_thread_sched;

  logic       CLK;
  logic       RST;
  logic [5:0] core_done;
  logic       NEXT_THREAD;
  logic [1:0] cpu_new_state;
  logic [2:0] ts_rd_num;
  logic [1:0] ts_rd;
  logic [2:0] thread_num;
  logic       thread_running;
  logic       RELOAD;
  logic       err;
`ifdef THREAD_SCHED_STATS_EN
  logic [31:0] idle_cnt;
`endif

  thread_sched_if #(.W(3)) ext_if ();

  thread_sched #(.N_CORES(3)) dut (
    .CLK            (CLK),
    .RST            (RST),
    .ext            (ext_if),
    .core_done      (core_done),
    .NEXT_THREAD    (NEXT_THREAD),
    .cpu_new_state  (cpu_new_state),
    .ts_rd_num      (ts_rd_num),
    .ts_rd          (ts_rd),
    .thread_num     (thread_num),
    .thread_running (thread_running),
    .RELOAD         (RELOAD),
`ifdef THREAD_SCHED_STATS_EN
    .idle_cnt       (idle_cnt),
`endif
    .err            (err)
  );

  int passed = 0;
  int total  = 0;
  logic [2:0] exp_q [$];

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic rd_chk(input string nm, input logic [2:0] num,
                        input logic [1:0] exp);
    ts_rd_num = num;
    #1;
    chk(nm, 32'(ts_rd), 32'(exp));
  endtask

  task automatic reset_dut();
    RST = 1'b1;
    ext_if.ext_wr_req = 1'b0;
    NEXT_THREAD = 1'b0;
    core_done = '0;
    tick();
    tick();
    RST = 1'b0;
  endtask

  task automatic ext_write(input logic [2:0] num, input logic [1:0] s,
                           output int c);
    ext_if.ext_wr_req   = 1'b1;
    ext_if.ext_wr_num   = num;
    ext_if.ext_wr_state = s;
    for (c = 0; c < 8; c++) begin
      @(negedge CLK);
      if (ext_if.ext_wr_ack) break;
      tick();
    end
    tick();
    ext_if.ext_wr_req = 1'b0;
  endtask

  task automatic wait_reload(input int max, output int n);
    n = 0;
    forever begin
      @(negedge CLK);
      if (RELOAD) break;
      n++;
      if (n > max) begin
        chk("reload_timeout", 32'd0, 32'd1);
        break;
      end
      tick();
    end
    tick();
  endtask

  always @(negedge CLK) begin
    if (!RST && RELOAD) begin
      if (exp_q.size() == 0)
        chk("reload_unexpected", 32'(thread_num), 32'hFF);
      else
        chk("reload_thread", 32'(thread_num), 32'(exp_q.pop_front()));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int c;
    int n;
    ext_if.ext_wr_num   = '0;
    ext_if.ext_wr_state = '0;
    cpu_new_state = '0;
    ts_rd_num = '0;

    // Reset state and first load from the external port.
    reset_dut();
    @(negedge CLK);
    chk("rst_thread_num", 32'(thread_num), 32'd0);
    chk("rst_running", 32'(thread_running), 32'd0);
    chk("rst_reload", 32'(RELOAD), 32'd0);
    chk("rst_ack", 32'(ext_if.ext_wr_ack), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    rd_chk("rst_tbl2", 3'd2, 2'b00);
    tick();
    exp_q.push_back(3'd2);
    ext_write(3'd2, 2'b01, c);
    chk("ext_ack_lat", 32'(c), 32'd0);
    wait_reload(6, n);
    chk("first_reload_lat", 32'(n), 32'd2);
    @(negedge CLK);
    chk("t1_running", 32'(thread_running), 32'd1);
    rd_chk("t1_tbl2_run", 3'd2, 2'b10);
    tick();

    // Rotating search 3 -> 4 -> 1 with minimum switch latency.
    reset_dut();
    exp_q.push_back(3'd3);
    ext_write(3'd3, 2'b01, c);
    wait_reload(6, n);
    ext_write(3'd1, 2'b01, c);
    ext_write(3'd4, 2'b01, c);
    tick();
    tick();
    exp_q.push_back(3'd4);
    NEXT_THREAD = 1'b1;
    cpu_new_state = 2'b11;
    tick();
    NEXT_THREAD = 1'b0;
    @(negedge CLK);
    chk("switch_min_lat", 32'(RELOAD), 32'd1);
    rd_chk("t2_tbl3_wait", 3'd3, 2'b11);
    tick();
    exp_q.push_back(3'd1);
    NEXT_THREAD = 1'b1;
    tick();
    NEXT_THREAD = 1'b0;
    @(negedge CLK);
    chk("wrap_reload", 32'(RELOAD), 32'd1);
    tick();
    core_done = 6'b001000;
    tick();
    core_done = '0;
    @(negedge CLK);
    rd_chk("core_done_rdy", 3'd3, 2'b01);
    chk("core_done_noerr", 32'(err), 32'd0);
    tick();

    // Only the running thread is ready: falls to IDLE then reselects it.
    reset_dut();
    exp_q.push_back(3'd0);
    ext_write(3'd0, 2'b01, c);
    wait_reload(6, n);
    tick();
    exp_q.push_back(3'd0);
    NEXT_THREAD = 1'b1;
    cpu_new_state = 2'b01;
    tick();
    NEXT_THREAD = 1'b0;
    @(negedge CLK);
    chk("idle_running_low", 32'(thread_running), 32'd0);
    chk("idle_no_reload", 32'(RELOAD), 32'd0);
    tick();
    wait_reload(6, n);
    chk("reselect_lat", 32'(n), 32'd1);
    @(negedge CLK);
    rd_chk("t3_tbl0_run", 3'd0, 2'b10);
    tick();

    // CPU write beats external write to the same thread.
    reset_dut();
    exp_q.push_back(3'd5);
    ext_write(3'd5, 2'b01, c);
    wait_reload(6, n);
    ext_if.ext_wr_req   = 1'b1;
    ext_if.ext_wr_num   = 3'd5;
    ext_if.ext_wr_state = 2'b00;
    @(negedge CLK);
    chk("ext_run_refused", 32'(ext_if.ext_wr_ack), 32'd0);
    tick();
    NEXT_THREAD = 1'b1;
    cpu_new_state = 2'b11;
    @(negedge CLK);
    chk("ext_lost_noack", 32'(ext_if.ext_wr_ack), 32'd0);
    tick();
    NEXT_THREAD = 1'b0;
    @(negedge CLK);
    chk("ext_retry_ack", 32'(ext_if.ext_wr_ack), 32'd1);
    rd_chk("cpu_val_stored", 3'd5, 2'b11);
    tick();
    ext_if.ext_wr_req = 1'b0;
    @(negedge CLK);
    rd_chk("ext_val_stored", 3'd5, 2'b00);
    tick();

    // Protocol errors are sticky until reset.
    reset_dut();
    core_done = 6'b000010;
    tick();
    core_done = '0;
    @(negedge CLK);
    chk("bad_done_err", 32'(err), 32'd1);
    rd_chk("bad_done_tbl1", 3'd1, 2'b00);
    tick();
    tick();
    tick();
    @(negedge CLK);
    chk("err_sticky", 32'(err), 32'd1);
    tick();
    reset_dut();
    @(negedge CLK);
    chk("err_cleared", 32'(err), 32'd0);
    tick();
    NEXT_THREAD = 1'b1;
    tick();
    NEXT_THREAD = 1'b0;
    @(negedge CLK);
    chk("next_idle_err", 32'(err), 32'd1);
    tick();

`ifdef THREAD_SCHED_STATS_EN
    reset_dut();
    @(negedge CLK);
    chk("idle_cnt_rst", idle_cnt, 32'd0);
    for (int i = 0; i < 10; i++) tick();
    @(negedge CLK);
    chk("idle_cnt_10", idle_cnt, 32'd10);
    tick();
    exp_q.push_back(3'd2);
    ext_write(3'd2, 2'b01, c);
    wait_reload(6, n);
    @(negedge CLK);
    chk("idle_cnt_run", idle_cnt, 32'd14);
    tick();
    tick();
    tick();
    @(negedge CLK);
    chk("idle_cnt_hold", idle_cnt, 32'd14);
    tick();
`endif

    chk("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
